prim_secded_scrub_ctrl: RTL

- Background scrubber for a SECDED-protected 39/32 memory.
- Walks every address, reads each word and decodes it with a prim_secded_39_32_dec instance.
- Single-bit errors: re-encodes the corrected data with a prim_secded_39_32_enc instance and writes it back.
- Double-bit errors: logged only.
- Sits between the memory arbiter (a low-priority requester port) and the CSR block (status/counters).

---
 rtl/prim_secded_scrub_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/prim_secded_scrub_ctrl.sv
// Background scrubber for a 39/32 SECDED-protected memory.
// Walks every word through a low-priority memory port, decodes it, writes
// back the corrected codeword on single-bit errors and logs double-bit errors.
//
// Code construction: data bit i uses the i-th 7-bit weight-3 column (in
// increasing numeric order), check bit j is the unit column 1<<j. Every
// column has odd weight and all columns are distinct, so an odd-weight
// syndrome marks a correctable error and an even, non-zero syndrome marks
// an uncorrectable one.

package prim_secded_39_32_pkg;

  function automatic logic [31:0] h_row(input int j);
    logic [31:0] row;
    int n;
    int w;
    row = '0;
    n = 0;
    for (int v = 0; v < 128; v++) begin
      w = 0;
      for (int b = 0; b < 7; b++) w += (v >> b) & 1;
      if (w == 3 && n < 32) begin
        if (((v >> j) & 1) != 0) row = row | (32'd1 << n);
        n++;
      end
    end
    return row;
  endfunction

  // h_mat[j] selects the data bits covered by check bit j
  localparam logic [6:0][31:0] HMat = {h_row(6), h_row(5), h_row(4), h_row(3),
                                       h_row(2), h_row(1), h_row(0)};

endpackage

module prim_secded_39_32_enc
  import prim_secded_39_32_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  assign data_o[31:0] = data_i;

  for (genvar j = 0; j < 7; j++) begin : g_chk
    assign data_o[32+j] = ^(data_i & HMat[j]);
  end

endmodule

module prim_secded_39_32_dec
  import prim_secded_39_32_pkg::*;
(
  input  logic [38:0] data_i,
  output logic [31:0] data_o,
  output logic [1:0]  err_o
);

  logic [6:0] syn;

  for (genvar j = 0; j < 7; j++) begin : g_syn
    assign syn[j] = ^(data_i[31:0] & HMat[j]) ^ data_i[32+j];
  end

  for (genvar i = 0; i < 32; i++) begin : g_fix
    assign data_o[i] = data_i[i] ^ (syn == {HMat[6][i], HMat[5][i], HMat[4][i],
                                            HMat[3][i], HMat[2][i], HMat[1][i],
                                            HMat[0][i]});
  end

  assign err_o[0] = ^syn;
  assign err_o[1] = ~(^syn) & (|syn);

endmodule

// state    | meaning
// ST_IDLE  | scrubbing disabled, waiting for scrub_en_i
// ST_WAIT  | interval timer counting down before the next read
// ST_READ  | read request for ptr held until granted
// ST_RESP  | waiting for read data, decode acted on in the rvalid_i cycle
// ST_WRITE | write-back of the corrected codeword held until granted
// ST_NEXT  | advance ptr (wrap + pass_done_o), then WAIT or IDLE
module prim_secded_scrub_ctrl #(
  parameter int Depth    = 1024,
  parameter int AddrW    = $clog2(Depth),
  parameter int Interval = 256,
  parameter int CntW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             scrub_en_i,
  output logic             req_o,
  input  logic             gnt_i,
  output logic             we_o,
  output logic [AddrW-1:0] addr_o,
  output logic [38:0]      wdata_o,
  input  logic             rvalid_i,
  input  logic [38:0]      rdata_i,
  output logic             busy_o,
  output logic             pass_done_o,
  output logic [CntW-1:0]  single_cnt_o,
  output logic [CntW-1:0]  double_cnt_o,
  output logic             double_err_o,
  output logic [AddrW-1:0] err_addr_o
);

  localparam int TimW = (Interval > 1) ? $clog2(Interval) : 1;
  localparam logic [TimW-1:0]  TimLoad  = TimW'(Interval - 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_RESP,
    ST_WRITE,
    ST_NEXT
  } state_e;

  state_e           state;
  logic [AddrW-1:0] ptr;
  logic [TimW-1:0]  tim;
  logic [31:0]      dec_data;
  logic [1:0]       dec_err;
  logic [38:0]      enc_cw;

  prim_secded_39_32_dec u_dec (
    .data_i (rdata_i),
    .data_o (dec_data),
    .err_o  (dec_err)
  );

  prim_secded_39_32_enc u_enc (
    .data_i (dec_data),
    .data_o (enc_cw)
  );

  assign busy_o = !(state inside {ST_IDLE, ST_WAIT});

  // Scrub sequencer with registered memory-port and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      tim          <= '0;
      req_o        <= 1'b0;
      we_o         <= 1'b0;
      addr_o       <= '0;
      wdata_o      <= '0;
      pass_done_o  <= 1'b0;
      double_err_o <= 1'b0;
      single_cnt_o <= '0;
      double_cnt_o <= '0;
      err_addr_o   <= '0;
    end else begin
      pass_done_o  <= 1'b0;
      double_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scrub_en_i) begin
            state <= ST_WAIT;
            tim   <= TimLoad;
          end
        end
        ST_WAIT: begin
          if (!scrub_en_i) begin
            state <= ST_IDLE;
          end else if (tim == '0) begin
            state  <= ST_READ;
            req_o  <= 1'b1;
            we_o   <= 1'b0;
            addr_o <= ptr;
          end else begin
            tim <= tim - 1'b1;
          end
        end
        ST_READ: begin
          if (gnt_i) begin
            state <= ST_RESP;
            req_o <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rvalid_i) begin
            if (dec_err[0]) begin
              if (single_cnt_o != {CntW{1'b1}}) single_cnt_o <= single_cnt_o + 1'b1;
              err_addr_o <= ptr;
              wdata_o    <= enc_cw;
              req_o      <= 1'b1;
              we_o       <= 1'b1;
              addr_o     <= ptr;
              state      <= ST_WRITE;
            end else begin
              if (dec_err[1]) begin
                if (double_cnt_o != {CntW{1'b1}}) double_cnt_o <= double_cnt_o + 1'b1;
                err_addr_o   <= ptr;
                double_err_o <= 1'b1;
              end
              // pass_done_o is raised on entry so it is high during NEXT
              pass_done_o <= (ptr == LastAddr);
              state       <= ST_NEXT;
            end
          end
        end
        ST_WRITE: begin
          if (gnt_i) begin
            req_o       <= 1'b0;
            we_o        <= 1'b0;
            wdata_o     <= '0;
            pass_done_o <= (ptr == LastAddr);
            state       <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          ptr <= (ptr == LastAddr) ? '0 : ptr + 1'b1;
          if (scrub_en_i) begin
            state <= ST_WAIT;
            tim   <= TimLoad;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
